// File: rtl/rename_pkg.sv
// rename_pkg: shared sizes, tag types and the renamed-uop record for the
// two-wide rename stage.
//   NUM_ARCH / NUM_PHYS : architectural registers / physical tags
//   ARCH_W / TAG_W      : index widths (TAG_W has one extra bit for SENTINEL)
//   SENTINEL            : tag meaning "architectural initial value"
package rename_pkg;

   localparam int unsigned NUM_ARCH = 32;
   localparam int unsigned NUM_PHYS = 128;
   localparam int unsigned ARCH_W   = $clog2(NUM_ARCH);
   localparam int unsigned TAG_W    = $clog2(NUM_PHYS) + 1;

   typedef logic [ARCH_W-1:0] arch_t;
   typedef logic [TAG_W-1:0]  tag_t;

   // Never issued by the free list, so it can never alias a live tag.
   localparam tag_t SENTINEL = tag_t'(NUM_PHYS);

   typedef struct packed {
      tag_t psrc1;
      tag_t psrc2;
      tag_t pdst;
      tag_t old_pdst;
      logic wr;
   } renamed_uop_t;

endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: bundles the rename stage's decode input, free-list,
// renamed output, commit and flush signals.
//   master : upstream/downstream environment side
//   slave  : rename_stage side
interface rename_stage_if;
   import rename_pkg::*;

   logic [1:0] in_valid;
   logic       in_ready;
   arch_t      in_src1_0, in_src2_0, in_dst_0;
   arch_t      in_src1_1, in_src2_1, in_dst_1;
   logic       in_wr_0, in_wr_1;

   tag_t       fl_tag_0, fl_tag_1, fl_num_items;
   logic       fl_read_1, fl_read_2;

   logic [1:0] out_valid;
   logic       out_ready;
   tag_t       out_psrc1_0, out_psrc2_0, out_pdst_0, out_old_pdst_0;
   tag_t       out_psrc1_1, out_psrc2_1, out_pdst_1, out_old_pdst_1;
   logic       out_wr_0, out_wr_1;

   logic [1:0] commit_valid;
   arch_t      commit_arch_0, commit_arch_1;
   tag_t       commit_pdst_0, commit_pdst_1;

   logic       flush;

   modport master (
      output in_valid, in_src1_0, in_src2_0, in_dst_0, in_src1_1, in_src2_1, in_dst_1,
      output in_wr_0, in_wr_1, fl_tag_0, fl_tag_1, fl_num_items, out_ready,
      output commit_valid, commit_arch_0, commit_arch_1, commit_pdst_0, commit_pdst_1, flush,
      input  in_ready, fl_read_1, fl_read_2, out_valid,
      input  out_psrc1_0, out_psrc2_0, out_pdst_0, out_old_pdst_0,
      input  out_psrc1_1, out_psrc2_1, out_pdst_1, out_old_pdst_1, out_wr_0, out_wr_1
   );

   modport slave (
      input  in_valid, in_src1_0, in_src2_0, in_dst_0, in_src1_1, in_src2_1, in_dst_1,
      input  in_wr_0, in_wr_1, fl_tag_0, fl_tag_1, fl_num_items, out_ready,
      input  commit_valid, commit_arch_0, commit_arch_1, commit_pdst_0, commit_pdst_1, flush,
      output in_ready, fl_read_1, fl_read_2, out_valid,
      output out_psrc1_0, out_psrc2_0, out_pdst_0, out_old_pdst_0,
      output out_psrc1_1, out_psrc2_1, out_pdst_1, out_old_pdst_1, out_wr_0, out_wr_1
   );

endinterface

// File: rtl/rat_array.sv
// rat_array: register alias table, NUM_ARCH entries of TAG_W bits.
//   rd_addr/rd_data : 6 asynchronous read ports
//   wr_en/addr/tag  : 2 write ports, port 1 wins on equal address
//   load_en/load_map: bulk load of the whole table (beats the write ports)
//   next_map        : next-state table, used as the source of a bulk copy
// Entry 0 is hardwired: writes to it are dropped.
module rat_array
   import rename_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  arch_t      rd_addr  [6],
   output tag_t       rd_data  [6],
   input  logic [1:0] wr_en,
   input  arch_t      wr_addr  [2],
   input  tag_t       wr_tag   [2],
   input  logic       load_en,
   input  tag_t       load_map [NUM_ARCH],
   output tag_t       next_map [NUM_ARCH]
);

   tag_t map_q [NUM_ARCH];

   always_comb begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
         next_map[i] = load_en ? load_map[i] : map_q[i];
      end
      if (!load_en) begin
         // Ascending loop order lets port 1 overwrite port 0.
         for (int unsigned k = 0; k < 2; k++) begin
            if (wr_en[k] && wr_addr[k] != '0) begin
               next_map[wr_addr[k]] = wr_tag[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
         if (reset) begin
            map_q[i] <= SENTINEL;
         end else begin
            map_q[i] <= next_map[i];
         end
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < 6; p++) begin
         rd_data[p] = map_q[rd_addr[p]];
      end
   end

endmodule

// File: rtl/rename_stage.sv
// rename_stage: two-wide register rename in front of the tag free list.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rename_stage_if.slave -- decode group in (in_*), free-list
//                head tags and pops (fl_*), registered renamed group out
//                (out_*), commit writes (commit_*) and flush.
// A speculative RAT is read for sources and updated at accept; a committed
// RAT follows the commit port and is bulk-copied into the speculative one
// on flush (including the commits of the flush cycle).
module rename_stage
   import rename_pkg::*;
(
   input logic           clk,
   input logic           reset,
   rename_stage_if.slave bus
);

   logic         need_0, need_1, enough, ready, accept;
   logic [1:0]   need;
   tag_t         tag_1;
   renamed_uop_t uop_0, uop_1, uop_0_q, uop_1_q;
   logic [1:0]   out_valid_q;

   arch_t spec_rd_addr [6];
   tag_t  spec_rd_data [6];
   arch_t spec_wr_addr [2];
   tag_t  spec_wr_tag  [2];
   arch_t cmt_rd_addr  [6];
   tag_t  cmt_rd_unused [6];
   arch_t cmt_wr_addr  [2];
   tag_t  cmt_wr_tag   [2];
   tag_t  cmt_next     [NUM_ARCH];
   tag_t  spec_next_unused [NUM_ARCH];
   tag_t  blank_map    [NUM_ARCH];

   assign need_0 = bus.in_valid[0] && bus.in_wr_0 && (bus.in_dst_0 != '0);
   assign need_1 = bus.in_valid[1] && bus.in_wr_1 && (bus.in_dst_1 != '0);
   assign need   = {1'b0, need_0} + {1'b0, need_1};
   assign enough = bus.fl_num_items >= tag_t'(need);

   assign ready  = !reset && !bus.flush && (out_valid_q == 2'b00 || bus.out_ready) && enough;
   assign accept = bus.in_valid[0] && ready;

   assign bus.in_ready  = ready;
   assign bus.fl_read_1 = accept && (need == 2'd1);
   assign bus.fl_read_2 = accept && (need == 2'd2);

   // Lane 1 takes the second head tag only when lane 0 consumed the first.
   assign tag_1 = need_0 ? bus.fl_tag_1 : bus.fl_tag_0;

   always_comb begin
      spec_rd_addr[0] = bus.in_src1_0;
      spec_rd_addr[1] = bus.in_src2_0;
      spec_rd_addr[2] = bus.in_dst_0;
      spec_rd_addr[3] = bus.in_src1_1;
      spec_rd_addr[4] = bus.in_src2_1;
      spec_rd_addr[5] = bus.in_dst_1;
      spec_wr_addr[0] = bus.in_dst_0;
      spec_wr_addr[1] = bus.in_dst_1;
      spec_wr_tag[0]  = bus.fl_tag_0;
      spec_wr_tag[1]  = tag_1;
      cmt_wr_addr[0]  = bus.commit_arch_0;
      cmt_wr_addr[1]  = bus.commit_arch_1;
      cmt_wr_tag[0]   = bus.commit_pdst_0;
      cmt_wr_tag[1]   = bus.commit_pdst_1;
      for (int unsigned p = 0; p < 6; p++) begin
         cmt_rd_addr[p] = '0;
      end
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
         blank_map[i] = SENTINEL;
      end
   end

   always_comb begin
      uop_0.psrc1    = spec_rd_data[0];
      uop_0.psrc2    = spec_rd_data[1];
      uop_0.pdst     = need_0 ? bus.fl_tag_0 : SENTINEL;
      uop_0.old_pdst = need_0 ? spec_rd_data[2] : SENTINEL;
      uop_0.wr       = need_0;

      // Lane 1 sees lane 0's fresh mapping for the same architectural reg.
      uop_1.psrc1    = (need_0 && bus.in_src1_1 == bus.in_dst_0) ? bus.fl_tag_0
                                                                 : spec_rd_data[3];
      uop_1.psrc2    = (need_0 && bus.in_src2_1 == bus.in_dst_0) ? bus.fl_tag_0
                                                                 : spec_rd_data[4];
      uop_1.pdst     = need_1 ? tag_1 : SENTINEL;
      uop_1.old_pdst = !need_1 ? SENTINEL :
                       (need_0 && bus.in_dst_1 == bus.in_dst_0) ? bus.fl_tag_0
                                                                : spec_rd_data[5];
      uop_1.wr       = need_1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 2'b00;
         uop_0_q     <= '0;
         uop_1_q     <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 2'b00;
      end else if (accept) begin
         out_valid_q <= bus.in_valid;
         uop_0_q     <= uop_0;
         uop_1_q     <= uop_1;
      end else if (bus.out_ready) begin
         out_valid_q <= 2'b00;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.out_psrc1_0    = uop_0_q.psrc1;
   assign bus.out_psrc2_0    = uop_0_q.psrc2;
   assign bus.out_pdst_0     = uop_0_q.pdst;
   assign bus.out_old_pdst_0 = uop_0_q.old_pdst;
   assign bus.out_wr_0       = uop_0_q.wr;
   assign bus.out_psrc1_1    = uop_1_q.psrc1;
   assign bus.out_psrc2_1    = uop_1_q.psrc2;
   assign bus.out_pdst_1     = uop_1_q.pdst;
   assign bus.out_old_pdst_1 = uop_1_q.old_pdst;
   assign bus.out_wr_1       = uop_1_q.wr;

   rat_array u_spec_rat (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (spec_rd_addr),
      .rd_data  (spec_rd_data),
      .wr_en    ({accept && need_1, accept && need_0}),
      .wr_addr  (spec_wr_addr),
      .wr_tag   (spec_wr_tag),
      .load_en  (bus.flush),
      .load_map (cmt_next),
      .next_map (spec_next_unused)
   );

   rat_array u_cmt_rat (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (cmt_rd_addr),
      .rd_data  (cmt_rd_unused),
      .wr_en    (bus.commit_valid),
      .wr_addr  (cmt_wr_addr),
      .wr_tag   (cmt_wr_tag),
      .load_en  (1'b0),
      .load_map (blank_map),
      .next_map (cmt_next)
   );

endmodule
